spi_master_tx: RTL and testbench

SPI_MASTER_TX -- requirements
Module: spi_master_tx

---
 rtl/spi_master_pkg.sv | 13 +
 rtl/spi_master_tx.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_tx.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and default widths for the SPI master transmit path.
package spi_master_pkg;

  localparam int SPI_WORD_WIDTH = 32;
  localparam int SPI_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRANSMIT  = 2'd1,
    WAIT_DATA = 2'd2
  } tx_state_e;

endpackage

// File: rtl/spi_master_tx.sv
// SPI master transmitter: serialises words pulled from the TX FIFO, MSB first,
// advancing one step per tx_edge_i pulse until the programmed bit count is sent.
// Optional quad-lane output is enabled by defining SPI_TX_QUAD_EN.
module spi_master_tx
  import spi_master_pkg::*;
#(
  parameter int WORD_WIDTH = SPI_WORD_WIDTH,
  parameter int CNT_WIDTH  = SPI_CNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  tx_edge_i,
  input  logic [CNT_WIDTH-1:0]  counter_in_i,
  input  logic                  counter_in_upd_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic                  sdo0_o,
`ifdef SPI_TX_QUAD_EN
  input  logic                  en_quad_i,
  output logic                  sdo1_o,
  output logic                  sdo2_o,
  output logic                  sdo3_o,
`endif
  output logic                  clk_en_o,
  output logic                  tx_done_o
);

  // Bits-left-in-word counter must be able to hold WORD_WIDTH itself.
  localparam int WLW = $clog2(WORD_WIDTH + 1);

`ifdef SPI_TX_QUAD_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif

  tx_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  target_q, target_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WLW-1:0]        word_left_q, word_left_d;
  logic [LANES-1:0]      sdo_q, sdo_d;
  logic                  clk_en_q, clk_en_d;
  logic                  tx_done_q, tx_done_d;
`ifdef SPI_TX_QUAD_EN
  logic                  quad_q, quad_d;
`endif

  logic                  quad_sel;
  logic [CNT_WIDTH:0]    step_cnt;
  logic [WLW-1:0]        step_word;
  logic [CNT_WIDTH:0]    target_eff;
  logic [CNT_WIDTH:0]    cnt_next;
  logic                  last_bit;
  logic                  word_end;
  logic                  ready;

  // Target bypass, step size and the end-of-transfer / end-of-word tests.
  always_comb begin
    target_d = counter_in_upd_i ? counter_in_i : target_q;
`ifdef SPI_TX_QUAD_EN
    quad_sel = (state_q == IDLE) ? en_quad_i : quad_q;
`else
    quad_sel = 1'b0;
`endif
    if (quad_sel) begin
      step_cnt        = (CNT_WIDTH+1)'(4);
      step_word       = WLW'(4);
      target_eff      = {1'b0, target_d} + (CNT_WIDTH+1)'(3);
      target_eff[1:0] = 2'b00;
    end else begin
      step_cnt   = (CNT_WIDTH+1)'(1);
      step_word  = WLW'(1);
      target_eff = {1'b0, target_d};
    end
    cnt_next = {1'b0, bit_cnt_q} + step_cnt;
    last_bit = (cnt_next == target_eff);
    word_end = (word_left_q == step_word);
  end

  // Next-state logic for the transfer FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_left_d = word_left_q;
    sdo_d       = sdo_q;
    tx_done_d   = 1'b0;
    ready       = 1'b0;
`ifdef SPI_TX_QUAD_EN
    quad_d      = quad_q;
`endif

    case (state_q)
      IDLE: begin
        if (en_i && (target_d != '0)) begin
          bit_cnt_d = '0;
`ifdef SPI_TX_QUAD_EN
          quad_d    = en_quad_i;
`endif
          if (data_valid_i) begin
            ready       = 1'b1;
            shift_d     = data_i;
            word_left_d = WLW'(WORD_WIDTH);
            state_d     = TRANSMIT;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end

      TRANSMIT: begin
        if (tx_edge_i) begin
`ifdef SPI_TX_QUAD_EN
          if (quad_q) begin
            sdo_d   = shift_q[WORD_WIDTH-1 -: 4];
            shift_d = shift_q << 4;
          end else begin
            sdo_d   = {3'b000, shift_q[WORD_WIDTH-1]};
            shift_d = shift_q << 1;
          end
`else
          sdo_d   = shift_q[WORD_WIDTH-1];
          shift_d = shift_q << 1;
`endif
          bit_cnt_d   = cnt_next[CNT_WIDTH-1:0];
          word_left_d = word_left_q - step_word;
          if (last_bit) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else if (word_end) begin
            if (data_valid_i) begin
              ready       = 1'b1;
              shift_d     = data_i;
              word_left_d = WLW'(WORD_WIDTH);
            end else begin
              state_d = WAIT_DATA;
            end
          end
        end
      end

      WAIT_DATA: begin
        if (data_valid_i) begin
          ready       = 1'b1;
          shift_d     = data_i;
          word_left_d = WLW'(WORD_WIDTH);
          state_d     = TRANSMIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    clk_en_d = (state_d == TRANSMIT);
  end

  // State and datapath registers; reset abandons any transfer silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      target_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      word_left_q <= '0;
      sdo_q       <= '0;
      clk_en_q    <= 1'b0;
      tx_done_q   <= 1'b0;
`ifdef SPI_TX_QUAD_EN
      quad_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      word_left_q <= word_left_d;
      sdo_q       <= sdo_d;
      clk_en_q    <= clk_en_d;
      tx_done_q   <= tx_done_d;
`ifdef SPI_TX_QUAD_EN
      quad_q      <= quad_d;
`endif
    end
  end

  assign data_ready_o = ready;
  assign sdo0_o       = sdo_q[0];
`ifdef SPI_TX_QUAD_EN
  assign sdo1_o       = sdo_q[1];
  assign sdo2_o       = sdo_q[2];
  assign sdo3_o       = sdo_q[3];
`endif
  assign clk_en_o     = clk_en_q;
  assign tx_done_o    = tx_done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx. The reference model treats a transfer
// as a bit stream: the words handed over so far, concatenated MSB first, cut
// to the programmed length. Define SPI_TX_QUAD_EN to also exercise quad mode.
module tb_spi_master_tx;

  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          tx_edge_i;
  logic [CW-1:0] counter_in_i;
  logic          counter_in_upd_i;
  logic [W-1:0]  data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic          sdo0_o;
  logic          clk_en_o;
  logic          tx_done_o;
`ifdef SPI_TX_QUAD_EN
  logic          en_quad_i;
  logic          sdo1_o;
  logic          sdo2_o;
  logic          sdo3_o;
`endif

  spi_master_tx #(.WORD_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .en_i             (en_i),
    .tx_edge_i        (tx_edge_i),
    .counter_in_i     (counter_in_i),
    .counter_in_upd_i (counter_in_upd_i),
    .data_i           (data_i),
    .data_valid_i     (data_valid_i),
    .data_ready_o     (data_ready_o),
    .sdo0_o           (sdo0_o),
`ifdef SPI_TX_QUAD_EN
    .en_quad_i        (en_quad_i),
    .sdo1_o           (sdo1_o),
    .sdo2_o           (sdo2_o),
    .sdo3_o           (sdo3_o),
`endif
    .clk_en_o         (clk_en_o),
    .tx_done_o        (tx_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // FIFO feeding the DUT: each entry waits 'delay' cycles once it reaches the head.
  logic [W-1:0] fifo_q[$];
  int           delay_q[$];
  int           head_wait = 0;

  // Reference model state.
  bit           m_active = 1'b0;
  bit           m_quad   = 1'b0;
  int           m_bits   = 0;
  int           m_target = 0;
  logic [W-1:0] m_words[$];
  logic [3:0]   exp_sdo    = 4'h0;
  logic         exp_done   = 1'b0;
  logic         exp_clk_en = 1'b0;

  int n_ready_obs = 0;
  int n_done_obs  = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic stream_bit(input int k);
    return m_words[k / W][W - 1 - (k % W)];
  endfunction

  task automatic push_word(input logic [W-1:0] w, input int d);
    fifo_q.push_back(w);
    delay_q.push_back(d);
    if (fifo_q.size() == 1) head_wait = d;
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    delay_q.delete();
    head_wait = 0;
  endtask

  // One clock cycle: present FIFO head, predict and check the handshake,
  // then check the registered outputs just after the edge.
  task automatic apply_stimulus();
    logic       exp_ready;
    logic       next_done;
    logic       shifted;
    logic [3:0] nib;
    int         avail;
    int         eff;
    int         lanes;
    if (fifo_q.size() > 0 && head_wait == 0) begin
      data_i       = fifo_q[0];
      data_valid_i = 1'b1;
    end else begin
      data_i       = $urandom();
      data_valid_i = 1'b0;
    end
    #1;
    exp_ready = 1'b0;
    next_done = 1'b0;
    shifted   = 1'b0;
    nib       = 4'h0;
    if (counter_in_upd_i) m_target = int'(counter_in_i);
    avail = m_words.size() * W;
    if (!m_active) begin
      if (en_i && m_target != 0) begin
        m_active = 1'b1;
        m_bits   = 0;
        m_words.delete();
        m_quad   = 1'b0;
`ifdef SPI_TX_QUAD_EN
        m_quad   = en_quad_i;
`endif
        exp_ready = data_valid_i;
      end
    end else begin
      lanes = m_quad ? 4 : 1;
      eff   = m_quad ? ((m_target + 3) / 4) * 4 : m_target;
      if (tx_edge_i && m_bits < avail) begin
        shifted = 1'b1;
        for (int j = 0; j < lanes; j++) nib[lanes-1-j] = stream_bit(m_bits + j);
        m_bits += lanes;
        if (m_bits == eff) begin
          next_done = 1'b1;
          m_active  = 1'b0;
        end else if (m_bits == avail) begin
          exp_ready = data_valid_i;
        end
      end else if (m_bits == avail) begin
        exp_ready = data_valid_i;
      end
    end
    check_output("data_ready", data_ready_o, exp_ready);
    if (data_ready_o) n_ready_obs++;
    if (exp_ready) begin
      m_words.push_back(fifo_q[0]);
      void'(fifo_q.pop_front());
      void'(delay_q.pop_front());
      head_wait = (delay_q.size() > 0) ? delay_q[0] : 0;
    end else if (fifo_q.size() > 0 && head_wait > 0) begin
      head_wait--;
    end
    @(posedge clk_i);
    #1;
    if (shifted) exp_sdo = nib;
    exp_done   = next_done;
    exp_clk_en = m_active && (m_bits < m_words.size() * W);
    check_output("clk_en", clk_en_o, exp_clk_en);
    check_output("tx_done", tx_done_o, exp_done);
    check_output("sdo0", sdo0_o, exp_sdo[0]);
`ifdef SPI_TX_QUAD_EN
    if (m_quad) check_output("sdo3_1", {sdo3_o, sdo2_o, sdo1_o}, exp_sdo[3:1]);
`endif
    if (tx_done_o) n_done_obs++;
  endtask

  task automatic rand_edge();
    tx_edge_i = ($urandom_range(0, 2) == 0);
  endtask

  // Program the bit count, start, run until the model says done, then check totals.
  task automatic run_transfer(input int tgt, input bit quad, input int exp_words, input string tag);
    int budget;
    n_ready_obs = 0;
    n_done_obs  = 0;
    counter_in_i     = CW'(tgt);
    counter_in_upd_i = 1'b1;
    rand_edge();
    apply_stimulus();
    counter_in_upd_i = 1'b0;
    en_i = 1'b1;
`ifdef SPI_TX_QUAD_EN
    en_quad_i = quad;
`else
    if (quad) $display("[TB] quad request ignored in single-lane build");
`endif
    rand_edge();
    apply_stimulus();
    en_i = 1'b0;
`ifdef SPI_TX_QUAD_EN
    en_quad_i = 1'b0;
`endif
    budget = 0;
    while (m_active && budget < 3000) begin
      rand_edge();
      apply_stimulus();
      budget++;
    end
    check_output({tag, " timeout"}, 32'(m_active), 32'd0);
    repeat (3) begin
      rand_edge();
      apply_stimulus();
    end
    check_output({tag, " ready_count"}, n_ready_obs, exp_words);
    check_output({tag, " done_count"}, n_done_obs, 1);
    flush_fifo();
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_bits     = 0;
    m_target   = 0;
    m_words.delete();
    exp_sdo    = 4'h0;
    exp_done   = 1'b0;
    exp_clk_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " data_ready"}, data_ready_o, 1'b0);
    check_output({tag, " sdo0"}, sdo0_o, 1'b0);
    check_output({tag, " clk_en"}, clk_en_o, 1'b0);
    check_output({tag, " tx_done"}, tx_done_o, 1'b0);
  endtask

  initial begin
    int tgt;
    int nw;
    int budget;
    rst_ni           = 1'b0;
    en_i             = 1'b0;
    tx_edge_i        = 1'b0;
    counter_in_i     = '0;
    counter_in_upd_i = 1'b0;
    data_i           = '0;
    data_valid_i     = 1'b0;
`ifdef SPI_TX_QUAD_EN
    en_quad_i        = 1'b0;
`endif
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("por");
    rst_ni = 1'b1;
    model_reset();

    $display("[TB] single word");
    push_word(32'hA5A5_0F0F, 0);
    run_transfer(32, 1'b0, 1, "single");

    $display("[TB] back-to-back words");
    push_word(32'hFFFF_0000, 0);
    push_word(32'h1234_5678, 0);
    run_transfer(64, 1'b0, 2, "b2b");

    $display("[TB] underflow stall");
    push_word(32'hDEAD_BEEF, 0);
    push_word(32'h0F1E_2D3C, 400);
    run_transfer(64, 1'b0, 2, "stall");

    $display("[TB] partial word");
    push_word(32'hABC0_0000, 0);
    push_word(32'h5555_5555, 0);
    run_transfer(12, 1'b0, 1, "partial");

    $display("[TB] zero target");
    push_word(32'h8000_0001, 0);
    n_ready_obs      = 0;
    counter_in_i     = '0;
    counter_in_upd_i = 1'b1;
    apply_stimulus();
    counter_in_upd_i = 1'b0;
    en_i = 1'b1;
    repeat (3) begin
      rand_edge();
      apply_stimulus();
    end
    en_i = 1'b0;
    check_output("zero ready_count", n_ready_obs, 0);
    flush_fifo();

    $display("[TB] reset mid-transfer");
    push_word(32'hC3C3_3C3C, 0);
    counter_in_i     = CW'(32);
    counter_in_upd_i = 1'b1;
    apply_stimulus();
    counter_in_upd_i = 1'b0;
    en_i = 1'b1;
    apply_stimulus();
    en_i = 1'b0;
    budget = 0;
    while (m_bits < 5 && budget < 500) begin
      rand_edge();
      apply_stimulus();
      budget++;
    end
    check_output("rst edge5 reached", 32'(m_bits), 32'd5);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("midrst hold");
    flush_fifo();
    model_reset();
    rst_ni     = 1'b1;
    n_done_obs = 0;
    repeat (6) begin
      rand_edge();
      apply_stimulus();
    end
    check_output("midrst done_count", n_done_obs, 0);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 8; t++) begin
      tgt = $urandom_range(1, 100);
      nw  = (tgt + W - 1) / W;
      for (int i = 0; i < nw; i++)
        push_word($urandom(), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 150));
      push_word($urandom(), 0);
      run_transfer(tgt, 1'b0, nw, "random");
    end

`ifdef SPI_TX_QUAD_EN
    $display("[TB] quad mode");
    push_word(32'h1357_9BDF, 0);
    run_transfer(32, 1'b1, 1, "quad");
    push_word(32'hFEDC_BA98, 0);
    run_transfer(10, 1'b1, 1, "quad_round");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
